// File: rtl/tx_serial_arbitro_if.sv
// Handshake bundle between the two character sources, the arbiter and the 7O1 transmitter.
// The slave modport is the arbiter's view; master is the view of whoever drives the requests.
interface tx_serial_arbitro_if;
    localparam int unsigned W_DADOS  = 7;
    localparam int unsigned W_ESTADO = 4;

    logic                req0;
    logic [W_DADOS-1:0]  dados0;
    logic                req1;
    logic [W_DADOS-1:0]  dados1;
    logic                ack0;
    logic                ack1;
    logic                fim0;
    logic                fim1;
    logic                erro;
    logic                tx_partida;
    logic [W_DADOS-1:0]  tx_dados;
    logic                tx_pronto;
    logic                ocupado;
    logic                db_dono;
    logic [W_ESTADO-1:0] db_estado;

    modport slave (
        input  req0, dados0, req1, dados1, tx_pronto,
        output ack0, ack1, fim0, fim1, erro, tx_partida, tx_dados,
               ocupado, db_dono, db_estado
    );

    modport master (
        output req0, dados0, req1, dados1, tx_pronto,
        input  ack0, ack1, fim0, fim1, erro, tx_partida, tx_dados,
               ocupado, db_dono, db_estado
    );
endinterface

// File: rtl/tx_serial_arbitro.sv
// Round-robin arbiter that shares one 7O1 serial transmitter between two requesters,
// latching the winner's character, pulsing partida and guarding the transfer with a watchdog.
module tx_serial_arbitro #(
    parameter int unsigned TIMEOUT   = 5000,
    parameter int unsigned W_TIMEOUT = 13
) (
    input logic                clock,
    input logic                reset,
    tx_serial_arbitro_if.slave bus
);

    localparam int unsigned W_DADOS  = 7;
    localparam int unsigned W_ESTADO = 4;

    typedef enum logic [W_ESTADO-1:0] {
        OCIOSO  = 4'b0000,
        PARTIDA = 4'b0001,
        ESPERA  = 4'b0010,
        CONCLUI = 4'b0011,
        ERRO    = 4'b1111
    } estado_t;

    estado_t              estado_q, estado_d;
    logic                 dono_q, dono_d;
    logic                 prio_q, prio_d;
    logic [W_DADOS-1:0]   dados_q, dados_d;
    logic [W_TIMEOUT-1:0] wd_q, wd_d;
    logic [W_TIMEOUT-1:0] wd_inc;
    logic                 grant;

    logic ack0_q, ack0_d;
    logic ack1_q, ack1_d;
    logic fim0_q, fim0_d;
    logic fim1_q, fim1_d;
    logic erro_q, erro_d;
    logic partida_q, partida_d;
    logic ocupado_q, ocupado_d;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            dono_q   <= 1'b0;
            prio_q   <= 1'b0;
            dados_q  <= '0;
            wd_q     <= '0;
        end else begin
            estado_q <= estado_d;
            dono_q   <= dono_d;
            prio_q   <= prio_d;
            dados_q  <= dados_d;
            wd_q     <= wd_d;
        end
    end

    // Next state: arbitration on idle, watchdog while waiting for pronto
    always_comb begin
        estado_d = estado_q;
        dono_d   = dono_q;
        prio_d   = prio_q;
        dados_d  = dados_q;
        wd_d     = wd_q;
        wd_inc   = wd_q + W_TIMEOUT'(1);
        grant    = (bus.req0 && bus.req1) ? prio_q : bus.req1;

        case (estado_q)
            OCIOSO: begin
                if (bus.req0 || bus.req1) begin
                    dono_d   = grant;
                    dados_d  = grant ? bus.dados1 : bus.dados0;
                    estado_d = PARTIDA;
                end
            end
            PARTIDA: begin
                wd_d     = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // wd_inc counts cycles since partida; pronto wins a tie with the timeout
                wd_d = wd_inc;
                if (bus.tx_pronto) begin
                    estado_d = CONCLUI;
                end else if (wd_inc == W_TIMEOUT'(TIMEOUT - 1)) begin
                    estado_d = ERRO;
                end
            end
            CONCLUI: begin
                prio_d   = ~dono_q;
                estado_d = OCIOSO;
            end
            ERRO: begin
                prio_d   = ~dono_q;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Output decode of the upcoming state so every pulse is a register
    always_comb begin
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        fim0_d    = 1'b0;
        fim1_d    = 1'b0;
        erro_d    = 1'b0;
        partida_d = 1'b0;
        ocupado_d = (estado_d != OCIOSO);

        case (estado_d)
            PARTIDA: begin
                partida_d = 1'b1;
                ack0_d    = ~dono_d;
                ack1_d    = dono_d;
            end
            CONCLUI: begin
                fim0_d = ~dono_d;
                fim1_d = dono_d;
            end
            ERRO: begin
                erro_d = 1'b1;
            end
            default: begin
                partida_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            fim0_q    <= 1'b0;
            fim1_q    <= 1'b0;
            erro_q    <= 1'b0;
            partida_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            fim0_q    <= fim0_d;
            fim1_q    <= fim1_d;
            erro_q    <= erro_d;
            partida_q <= partida_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.fim0       = fim0_q;
    assign bus.fim1       = fim1_q;
    assign bus.erro       = erro_q;
    assign bus.tx_partida = partida_q;
    assign bus.tx_dados   = dados_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.db_dono    = dono_q;
    assign bus.db_estado  = estado_q;

endmodule

// File: tb/tb_tx_serial_arbitro.sv
// Bench for tx_serial_arbitro: directed scenarios plus random traffic against a
// transaction-level model of grant order, pulse timing and watchdog expiry.
module tb_tx_serial_arbitro;

    localparam int unsigned TIMEOUT   = 5000;
    localparam int unsigned W_TIMEOUT = 13;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    bit   prio_m;

    tx_serial_arbitro_if bus ();

    tx_serial_arbitro #(
        .TIMEOUT   (TIMEOUT),
        .W_TIMEOUT (W_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {ack0, ack1, fim0, fim1, erro, tx_partida}
    function automatic logic [5:0] pulses();
        return {bus.ack0, bus.ack1, bus.fim0, bus.fim1, bus.erro, bus.tx_partida};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_pulses"}, 32'(pulses()), 32'd0);
        check({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
        check({tag, "_estado"}, 32'(bus.db_estado), 32'd0);
    endtask

    // Called at the negedge of the partida cycle; walks the transfer to its closing cycle.
    // dly = cycles after partida at which pronto pulses; out of range means it never comes.
    task automatic follow(input bit g, input logic [6:0] dexp, input int dly, input bit drop);
        bit         ok;
        int         e;
        logic [5:0] pexp;
        ok = (dly >= 1) && (dly <= int'(TIMEOUT) - 1);
        e  = ok ? dly + 1 : int'(TIMEOUT);
        for (int c = 0; c <= e; c++) begin
            pexp = 6'b000000;
            if (c == 0)      pexp = g ? 6'b010001 : 6'b100001;
            else if (c == e) pexp = !ok ? 6'b000010 : (g ? 6'b000100 : 6'b001000);
            check("pulses", 32'(pulses()), 32'(pexp));
            check("ocupado", 32'(bus.ocupado), 32'd1);
            check("tx_dados", 32'(bus.tx_dados), 32'(dexp));
            if (c == 0) begin
                check("dono_grant", 32'(bus.db_dono), 32'(g));
                check("estado_partida", 32'(bus.db_estado), 32'h1);
            end
            if (c == 1) check("estado_espera", 32'(bus.db_estado), 32'h2);
            if (c == e) begin
                check("dono_end", 32'(bus.db_dono), 32'(g));
                check("estado_end", 32'(bus.db_estado), ok ? 32'h3 : 32'hF);
            end
            bus.tx_pronto = ok && (c == dly);
            if (drop && c == 0) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            if (drop && c > 0) begin
                bus.dados0 = 7'($urandom);
                bus.dados1 = 7'($urandom);
            end
            if (c < e) @(negedge clock);
        end
        bus.tx_pronto = 1'b0;
        prio_m = ~g;
    endtask

    task automatic run_xact(input bit r0, input bit r1, input logic [6:0] d0,
                            input logic [6:0] d1, input int dly, input bit drop);
        bit g;
        @(negedge clock);
        check_idle("idle");
        bus.req0   = r0;
        bus.req1   = r1;
        bus.dados0 = d0;
        bus.dados1 = d1;
        g = (r0 && r1) ? prio_m : r1;
        @(negedge clock);
        follow(g, g ? d1 : d0, dly, drop);
    endtask

    initial begin
        logic [6:0] d0, d1;
        int         sel, dly;
        n_checks = 0;
        n_fail   = 0;
        prio_m   = 1'b0;
        reset         = 1'b0;
        bus.req0      = 1'b1;
        bus.req1      = 1'b0;
        bus.dados0    = 7'h41;
        bus.dados1    = 7'h00;
        bus.tx_pronto = 1'b0;

        // Reset held with req0 pending, then a full-length frame from requester 0
        repeat (3) @(negedge clock);
        check_idle("reset");
        check("reset_tx_dados", 32'(bus.tx_dados), 32'd0);
        check("reset_dono", 32'(bus.db_dono), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        follow(1'b0, 7'h41, 4340, 1'b1);

        // Requester 1 alone with pronto never arriving: watchdog abort
        run_xact(1'b0, 1'b1, 7'h10, 7'h22, -1, 1'b1);

        // Both requesting continuously: alternation starting with requester 0
        for (int i = 0; i < 4; i++)
            run_xact(1'b1, 1'b1, 7'h30, 7'h31, 3 + i, 1'b0);

        // Pronto on the very last watchdog cycle still completes normally
        run_xact(1'b1, 1'b0, 7'h5A, 7'h00, int'(TIMEOUT) - 1, 1'b1);

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(1, 3));
            d0  = 7'($urandom);
            d1  = 7'($urandom);
            dly = int'($urandom_range(1, 40));
            run_xact(sel[0], sel[1], d0, d1, dly, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a requester-0 transfer
        @(negedge clock);
        bus.req0   = 1'b1;
        bus.req1   = 1'b0;
        bus.dados0 = 7'h55;
        @(negedge clock);
        check("mid_partida", 32'(pulses()), 32'h21);
        bus.req0 = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_tx_dados", 32'(bus.tx_dados), 32'd0);
        check("mid_reset_dono", 32'(bus.db_dono), 32'd0);
        prio_m = 1'b0;
        @(negedge clock);
        d1 = 7'($urandom);
        bus.req1   = 1'b1;
        bus.dados1 = d1;
        repeat (2) begin
            @(negedge clock);
            check("held_reset_pulses", 32'(pulses()), 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        follow(1'b1, d1, 20, 1'b1);

        @(negedge clock);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_serial_arbitro.md
Name: tx_serial_arbitro

Overview:
- Round-robin arbiter and sequencer that shares one tx_serial_7O1 transmitter between two character sources (requesters 0 and 1).
- Grants the transmitter to one requester, latches its 7-bit character, and pulses partida to the transmitter.
- Waits for pronto, then reports completion to the owning requester.
- A watchdog aborts a transmission that never completes. Sits between the application logic and the transmitter in the serial-out path.

Parameters:
TIMEOUT, 5000, clock cycles allowed in ESPERA before abort (one 7O1 frame = 10 bits x 434 = 4340 clocks, plus margin)
W_TIMEOUT, 13, watchdog counter width; must satisfy 2^W_TIMEOUT > TIMEOUT

Ports:
clock  input  1  system clock, 50 MHz, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
req0  input  1  requester 0 wants to send; level, sampled only in OCIOSO
dados0  input  7  requester 0 ASCII character
req1  input  1  requester 1 wants to send
dados1  input  7  requester 1 ASCII character
ack0  output  1  one-cycle pulse: dados0 latched, requester 0 may change dados0/req0
ack1  output  1  one-cycle pulse: dados1 latched
fim0  output  1  one-cycle pulse: requester 0 character fully transmitted
fim1  output  1  one-cycle pulse: requester 1 character fully transmitted
erro  output  1  one-cycle pulse: watchdog abort of current owner's transmission
tx_partida  output  1  to transmitter partida; one-cycle pulse
tx_dados  output  7  to transmitter dados_ascii; latched character
tx_pronto  input  1  from transmitter pronto
ocupado  output  1  1 in every state except OCIOSO
db_dono  output  1  current/last owner (0 or 1)
db_estado  output  4  state code (see below)

Behaviour:
- Reset (reset=0, async):
  - State OCIOSO; all pulse outputs 0; tx_dados=0; ocupado=0.
  - Priority register prio=0 (requester 0 favoured); db_dono=0; watchdog=0.
- States and codes: OCIOSO=0000, PARTIDA=0001, ESPERA=0010, CONCLUI=0011, ERRO=1111; any other code -> OCIOSO.
- OCIOSO:
  - No req: stay.
  - Exactly one req: grant that requester.
  - Both req: grant the requester equal to prio.
  - On grant, at the same edge: dono <= grantee; tx_dados <= grantee's dados; -> PARTIDA.
- PARTIDA (exactly 1 cycle):
  - tx_partida=1 and ack<dono>=1 in this cycle; watchdog cleared.
  - -> ESPERA.
- ESPERA:
  - Watchdog increments every cycle.
  - tx_pronto=1 -> CONCLUI. tx_pronto takes precedence over timeout in the same cycle.
  - Else if watchdog == TIMEOUT-1 -> ERRO.
  - req inputs and dados inputs are ignored here; req dropping does not abort.
- CONCLUI (1 cycle): fim<dono>=1; prio <= ~dono; -> OCIOSO.
- ERRO (1 cycle): erro=1; prio <= ~dono (the failing requester loses priority); -> OCIOSO. No fim pulse is issued.
- Latency:
  - req sampled high at edge k (in OCIOSO) -> tx_partida high during cycle k..k+1.
  - Minimum gap between consecutive partida pulses = transmission time + 3 cycles.
- tx_dados:
  - Changes only on a grant edge.
  - Holds its value through ESPERA and CONCLUI/ERRO, and afterwards until the next grant.
- A requester holding req high after its fim is re-granted only if the other requester is idle, or if it holds prio.
- Outputs are registered state decodes; no combinational path from req/tx_pronto to any output.
- Reset mid-operation: immediate return to reset values. The transmitter is reset by the same signal, so no pronto is awaited.

Test Plan:
1. Reset held low 3 cycles with req0=1 -> all outputs 0, db_estado=0000; release -> grant requester 0 on the next edge.
2. req0=1, dados0=0x41 -> next cycle tx_partida=1, ack0=1, tx_dados=0x41; model pronto after 4340 cycles -> fim0 one cycle later, back to OCIOSO; ack1/fim1/erro never assert.
3. req0=req1=1 held, dados0=0x30, dados1=0x31 -> grant order 0,1,0,1. tx_dados sequence 0x30,0x31,0x30,0x31; each partida preceded by the prior fim.
4. req1=1 only, tx_pronto tied 0 -> erro pulse exactly TIMEOUT cycles after partida cycle; no fim1. Then with req0=req1=1, requester 0 is granted.
5. tx_pronto=1 in the same cycle the watchdog reaches TIMEOUT-1 -> CONCLUI taken, fim asserted, erro stays 0.
6. Reset asserted mid-ESPERA (req0 owner) -> outputs clear asynchronously, no fim0/erro. After release with req1=1 only -> requester 1 granted, tx_dados=dados1.
